imm_extend_unit: RTL and testbench
==================================

# imm_extend_unit

Parametrised, handshaked immediate-extension stage for the processor datapath. It takes an IN_W-bit instruction immediate plus a mode, and produces an OUT_W-bit operand in one of four forms: sign-extended, zero-extended, upper-placed, or branch-offset. Results pass through a registered two-entry skid buffer with valid/ready flow control. The block sits between instruction decode and the ALU/branch-target operand mux, and is intended for the pipelined datapath.

## Interface
Parameters:
- IN_W, default 16: immediate width. Must be ≥ 2.
- OUT_W, default 32: operand width. Must be ≥ IN_W + 2.

Ports. One clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  an immediate and mode are presented.
- in_ready  out  1  the block can accept this cycle.
- in_imm  in  IN_W  raw immediate.
- in_mode  in  2  extension mode (encodings in Operation).
- out_valid  out  1  out_data holds a result.
- out_ready  in  1  the consumer accepts out_data this cycle.
- out_data  out  OUT_W  extended operand.

## Operation
- Mode encodings:
  - MODE_SEXT (0): replicate in_imm[IN_W-1] into bits OUT_W-1..IN_W.
  - MODE_ZEXT (1): zero-fill bits OUT_W-1..IN_W.
  - MODE_UPPER (2): in_imm occupies bits OUT_W-1..OUT_W-IN_W; the low bits are zero.
  - MODE_BRANCH (3): sign-extend, then shift left by 2. The two LSBs are 0 and the bits shifted out at the top are discarded.
- Extension is computed combinationally from in_imm/in_mode at the time of acceptance. Only the result is stored; mode is not retained.
- An input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- Storage is a main register (drives out_data/out_valid) and one skid register.
- State is encoded as {main_v, skid_v} with the following transitions:
  - EMPTY (00): an input transfer loads main and goes to ONE.
  - ONE (10):
    - input and output together: main is reloaded, state stays ONE.
    - input only: load skid, go to FULL.
    - output only: go to EMPTY.
  - FULL (11): in_ready = 0. An output transfer moves skid into main and goes to ONE. No input is accepted in the same cycle.
  - 01 is illegal and unreachable. The assertion checks it.
- in_ready = !skid_v. It is a register output, with no combinational path from out_ready.
- Ordering is strict FIFO. There is no drop and no duplicate.
- While out_valid = 1 and out_ready = 0, out_data must not change.

## Timing
- Reset values (asynchronous, immediate on rst_n low): main_v = 0, skid_v = 0, out_valid = 0, out_data = 0, in_ready = 1.
- Asserting reset mid-operation discards both entries. in_ready returns to 1 and out_valid to 0 within the same cycle, without waiting for a clock edge.
- Latency: a beat accepted at edge N is presented on out_data/out_valid after edge N (visible in cycle N+1).
- Throughput: 1 beat per cycle when out_ready is held at 1.
- Back-pressure: at most 2 beats are accepted after out_ready falls. in_ready drops the cycle after the second one is accepted.
- Once out_ready rises, in_ready returns to 1 one cycle after skid drains.

## Structure
- Package imm_ext_pkg holds the MODE_* localparams (2-bit) and the mode type.
- Sub-module imm_ext_core is purely combinational: parameters IN_W and OUT_W, inputs imm and mode, output ext. It is instantiated once at the input side, ahead of the skid buffer.
- The top level contains the storage registers, the state, and the handshake logic only.
- Elaboration-time check: fail if OUT_W < IN_W + 2.

## Test plan
All scenarios use IN_W = 16, OUT_W = 32 with out_ready held at 1 unless stated.
- Modes on imm 0x8004:
  - SEXT gives 0xFFFF8004.
  - ZEXT gives 0x00008004.
  - UPPER gives 0x80040000.
  - BRANCH gives 0xFFFE0010.
  - Each result appears one cycle after acceptance.
- Boundaries:
  - SEXT 0x7FFF gives 0x00007FFF.
  - BRANCH 0xFFFF gives 0xFFFFFFFC.
  - UPPER 0x0000 gives 0x00000000.
  - BRANCH 0x4000 gives 0x00010000.
- Back-pressure:
  - Setup: stream 0x0001, 0x0002, 0x0003 (SEXT) with out_ready = 0 for 4 cycles.
  - During the stall: only the first two are accepted, in_ready = 0, and out_data holds 0x00000001.
  - After release: outputs appear in order 1, 2, 3, and 0x0003 is accepted the cycle after in_ready rises.
- Simultaneous events:
  - Setup: in state ONE, in_valid = 1 and out_ready = 1 every cycle for 8 beats.
  - Required: skid never fills, in_ready stays 1, and there is one output per cycle with no gaps.
- Reset mid-operation:
  - Setup: FULL state (two beats held); pulse rst_n low between clock edges.
  - Required: out_valid = 0 and in_ready = 1 immediately. After release the next beat 0x00FF (ZEXT) outputs 0x000000FF, with no stale data.
- Randomised soak:
  - 10k beats with random valid/ready and random modes against a reference-model scoreboard.
  - Required: zero mismatches, the 01 state never occurs, and out_data is stable under stall.

Source files
------------

// File: rtl/imm_ext_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imm_ext_pkg
// Brief    : Shared mode encodings and buffer-state type for imm_extend_unit.
// Revision : 1.0 - initial release
// ============================================================================
package imm_ext_pkg;

  // Extension mode encodings
  localparam logic [1:0] MODE_SEXT   = 2'd0;
  localparam logic [1:0] MODE_ZEXT   = 2'd1;
  localparam logic [1:0] MODE_UPPER  = 2'd2;
  localparam logic [1:0] MODE_BRANCH = 2'd3;

  typedef logic [1:0] imm_mode_t;

  // Buffer occupancy encoded as {main_v, skid_v}; 2'b01 is never entered.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } buf_state_e;

endpackage : imm_ext_pkg
`default_nettype wire

// File: rtl/imm_ext_core.sv
`default_nettype none
// ============================================================================
// Module   : imm_ext_core
// Brief    : Combinational immediate extender (sign, zero, upper, branch).
// Revision : 1.0 - initial release
// ============================================================================
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  imm,
  input  imm_mode_t        mode,
  output logic [OUT_W-1:0] ext
);

  logic [OUT_W-1:0] sext;

  assign sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};

  // Select the extended form; branch offsets drop the bits shifted past the top
  always_comb begin
    ext = sext;
    case (mode)
      MODE_SEXT:   ext = sext;
      MODE_ZEXT:   ext = {{(OUT_W-IN_W){1'b0}}, imm};
      MODE_UPPER:  ext = {imm, {(OUT_W-IN_W){1'b0}}};
      MODE_BRANCH: ext = {sext[OUT_W-3:0], 2'b00};
      default:     ext = sext;
    endcase
  end

endmodule : imm_ext_core
`default_nettype wire

// File: rtl/imm_extend_unit.sv
`default_nettype none
// ============================================================================
// Module   : imm_extend_unit
// Brief    : Handshaked immediate extension with a registered two-entry
//            skid buffer (main register drives the output, skid catches the
//            beat accepted while the consumer stalls).
// Revision : 1.0 - initial release
// ============================================================================
module imm_extend_unit
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data
);

  if (IN_W < 2) begin : g_in_w_check
    $error("imm_extend_unit: IN_W must be at least 2");
  end
  if (OUT_W < IN_W + 2) begin : g_out_w_check
    $error("imm_extend_unit: OUT_W must be at least IN_W + 2");
  end

  buf_state_e       state_q;
  buf_state_e       state_d;
  logic [1:0]       state_bits;
  logic [OUT_W-1:0] ext;
  logic [OUT_W-1:0] skid_data;
  logic             in_xfer;
  logic             out_xfer;
  logic             load_main_in;
  logic             load_main_skid;
  logic             load_skid;

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .imm  (in_imm),
    .mode (in_mode),
    .ext  (ext)
  );

  // Both handshake outputs come straight from state flops, so reset clears
  // them immediately and out_ready has no path to in_ready.
  assign state_bits = state_q;
  assign out_valid  = state_bits[1];
  assign in_ready   = ~state_bits[0];
  assign in_xfer    = in_valid & in_ready;
  assign out_xfer   = out_valid & out_ready;

  // Occupancy state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next occupancy and which register loads this cycle
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          load_main_in = 1'b1;
          state_d      = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          load_main_in = 1'b1;
        end else if (in_xfer) begin
          load_skid = 1'b1;
          state_d   = ST_FULL;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_xfer) begin
          load_main_skid = 1'b1;
          state_d        = ST_ONE;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // Data storage; main only changes on a load, so a stalled output holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      skid_data <= '0;
    end else begin
      if (load_main_in) begin
        out_data <= ext;
      end else if (load_main_skid) begin
        out_data <= skid_data;
      end
      if (load_skid) begin
        skid_data <= ext;
      end
    end
  end

  // A skid entry without a main entry would break FIFO order
  a_no_skid_only: assert property (@(posedge clk) disable iff (!rst_n)
    state_bits != 2'b01);

endmodule : imm_extend_unit
`default_nettype wire

// File: tb/tb_imm_extend_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_extend_unit
// Brief    : Self-checking bench for imm_extend_unit (IN_W=16, OUT_W=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_extend_unit;

  localparam int IN_W  = 16;
  localparam int OUT_W = 32;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;

  int tests  = 0;
  int failed = 0;

  imm_extend_unit #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference extension from the arithmetic meaning of each mode
  function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
    longint sv;
    longint uv;
    sv = longint'($signed(imm));
    uv = longint'(imm);
    case (mode)
      2'd0:    return 32'(sv);
      2'd1:    return 32'(uv);
      2'd2:    return 32'(uv * 65536);
      default: return 32'(sv * 4);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one beat with out_ready=1, check it appears one cycle later, then drain
  task automatic send_one(input string tag, input logic [15:0] imm, input logic [1:0] mode,
                          input logic [31:0] exp);
    in_valid  = 1'b1;
    in_imm    = imm;
    in_mode   = mode;
    out_ready = 1'b1;
    #1;
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk(tag, out_data, exp);
    @(negedge clk);
    #1;
    chk({tag, "_drain"}, 32'(out_valid), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] q[$];
    logic        prev_stall;
    logic [31:0] prev_data;
    int          accepted;
    int          cycles;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_imm    = '0;
    in_mode   = 2'd0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_data",  out_data,       32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Modes and boundaries
    send_one("sext_8004",   16'h8004, 2'd0, 32'hFFFF8004);
    send_one("zext_8004",   16'h8004, 2'd1, 32'h00008004);
    send_one("upper_8004",  16'h8004, 2'd2, 32'h80040000);
    send_one("branch_8004", 16'h8004, 2'd3, 32'hFFFE0010);
    send_one("sext_7fff",   16'h7FFF, 2'd0, 32'h00007FFF);
    send_one("branch_ffff", 16'hFFFF, 2'd3, 32'hFFFFFFFC);
    send_one("upper_0000",  16'h0000, 2'd2, 32'h00000000);
    send_one("branch_4000", 16'h4000, 2'd3, 32'h00010000);

    // Back-pressure: 3 beats, consumer stalled for 4 cycles
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 2'd0;
    in_imm    = 16'h0001;
    #1;
    chk("bp_rdy0", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_imm = 16'h0002;
    #1;
    chk("bp_rdy1", 32'(in_ready), 32'd1);
    chk("bp_hold1", out_data, 32'h1);
    @(negedge clk);
    in_imm = 16'h0003;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("bp_stall_rdy", 32'(in_ready), 32'd0);
      chk("bp_stall_vld", 32'(out_valid), 32'd1);
      chk("bp_stall_data", out_data, 32'h1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rel_rdy", 32'(in_ready), 32'd0);
    chk("bp_out1", out_data, 32'h1);
    @(negedge clk);
    #1;
    chk("bp_rdy_back", 32'(in_ready), 32'd1);
    chk("bp_out2", out_data, 32'h2);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("bp_out3_vld", 32'(out_valid), 32'd1);
    chk("bp_out3", out_data, 32'h3);
    @(negedge clk);
    #1;
    chk("bp_empty", 32'(out_valid), 32'd0);
    @(negedge clk);

    // Simultaneous in/out for 8 beats: no gaps, skid never used
    out_ready = 1'b1;
    in_mode   = 2'd1;
    for (int k = 0; k < 9; k++) begin
      in_valid = (k < 8);
      in_imm   = 16'(16'h0100 + k);
      #1;
      chk("sim_rdy", 32'(in_ready), 32'd1);
      if (k > 0) begin
        chk("sim_vld", 32'(out_valid), 32'd1);
        chk("sim_data", out_data, ref_ext(16'(16'h0100 + k - 1), 2'd1));
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);

    // Reset while FULL
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 2'd0;
    in_imm    = 16'h1111;
    @(negedge clk);
    in_imm = 16'h2222;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("full_rdy", 32'(in_ready), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_vld", 32'(out_valid), 32'd0);
    chk("arst_rdy", 32'(in_ready),  32'd1);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    send_one("post_rst_zext", 16'h00FF, 2'd1, 32'h000000FF);

    // Randomised soak against a FIFO scoreboard
    prev_stall = 1'b0;
    prev_data  = '0;
    accepted   = 0;
    cycles     = 0;
    while ((accepted < 10000 || q.size() > 0) && cycles < 40000) begin
      in_valid  = (accepted < 10000) && ($urandom_range(0, 99) < 80);
      in_imm    = 16'($urandom);
      in_mode   = 2'($urandom);
      out_ready = ($urandom_range(0, 99) < 80);
      #1;
      chk("soak_state01", 32'(!out_valid && !in_ready), 32'd0);
      chk("soak_rdy", 32'(in_ready), 32'(q.size() < 2));
      chk("soak_vld", 32'(out_valid), 32'(q.size() > 0));
      if (prev_stall) begin
        chk("soak_stable", out_data, prev_data);
      end
      if (out_valid && out_ready && q.size() > 0) begin
        chk("soak_data", out_data, q[0]);
        void'(q.pop_front());
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_ext(in_imm, in_mode));
        accepted++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      cycles++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("soak_timeout", 32'(cycles < 40000), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule : tb_imm_extend_unit
`default_nettype wire
